dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Memory-side responder for the CPU core's data-SRAM request interface: read control, write control, address, write data in; read data out.
- Accepts one load or store at a time and drives a single-port synchronous-read word SRAM with byte enables.
- Performs load alignment and sign/zero extension, plus store byte-lane steering.
- Splits word-crossing misaligned accesses into two SRAM beats. Sits between the execute/memory stages and the data RAM macro.

Parameters:
- XLEN, 32, data/address width (only 32 supported).
- ADDR_BASE, 32'h8000_0000, byte address of SRAM word 0.
- DEPTH_LOG2, 14, log2 of SRAM depth in words.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  responder idle, request accepted when req_valid&&req_ready
- req_rd_ctrl  in  3  0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6/7 illegal
- req_wr_ctrl  in  2  0 none, 1 SB, 2 SH, 3 SW
- req_addr  in  XLEN  byte address
- req_wdata  in  XLEN  store data, right-justified
- resp_valid  out  1  one-cycle completion pulse (loads and stores)
- resp_rdata  out  XLEN  extended load data, 0 for stores and errors
- resp_err  out  1  qualifies resp_valid: out-of-range, illegal ctrl, or both ctrls nonzero
- sram_ce  out  1  SRAM access enable
- sram_we  out  1  write when sram_ce
- sram_be  out  4  byte-lane write enables
- sram_addr  out  DEPTH_LOG2  word index
- sram_wdata  out  32  lane-steered write data
- sram_rdata  in  32  read data, valid the cycle after a read beat

Behaviour:
- Reset, asynchronous on rst_n low:
  - state=IDLE.
  - Outputs: req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, sram_ce=0, sram_we=0, sram_be=0.
  - All internal request registers cleared.
  - Reset mid-operation abandons the transaction silently; no response is produced.
- Request classification:
  - A request with both ctrls 0 is accepted and returns resp_valid, resp_err=0, resp_rdata=0 after 1 cycle; no SRAM beat.
  - Offset = req_addr - ADDR_BASE. Out of range if offset >= 4<<DEPTH_LOG2 or the last accessed byte crosses the top.
  - Size: 1 for B, 2 for H, 4 for W.
  - Split iff (addr[1:0]+size) > 4: H at addr[1:0]=3, W at 1..3.
- FSM states: IDLE, BEAT0, BEAT1, RESP.
  - IDLE: req_ready=1. On accept, register the request, then:
    - error -> RESP with err;
    - no-op -> RESP;
    - else -> BEAT0.
  - BEAT0: drive sram_ce with word index of offset[DEPTH_LOG2+1:2]. Then BEAT1 if split, else RESP.
  - BEAT1: drive word index+1, lanes for the spill bytes, then RESP.
  - RESP: resp_valid=1 for exactly one cycle, then IDLE. req_ready=0 in every state except IDLE.
- Latency: accept at edge T.
  - Aligned/non-split: resp_valid high in cycle T+2.
  - Split: resp_valid high in cycle T+3.
  - Error/no-op: resp_valid high in cycle T+1.
- No response backpressure: the requester must sample resp_valid when it pulses.
- Store steering:
  - sram_wdata = wdata rotated left by 8*addr[1:0].
  - BEAT0 be = size mask << addr[1:0], truncated to 4 bits.
  - BEAT1 be = spill lanes at low bytes.
  - Example: SW at addr[1:0]=2 gives BEAT0 be=4'b1100, BEAT1 be=4'b0011.
- Load assembly:
  - Capture sram_rdata the cycle after each read beat and concatenate {beat1,beat0}.
  - Shift right by 8*addr[1:0]. Sign-extend for LB/LH, zero-extend for LBU/LHU/LW.
- sram_we=1 only during beats of store requests; sram_ce=0 outside BEAT0/BEAT1.
- A new request presented during RESP is not accepted until the following IDLE cycle.

Optional Feature:
- Macro: DMEM_MISALIGN_SPLIT_EN.
- When defined: split behaviour as above.
- When undefined:
  - Any split-class access completes with resp_err=1 at T+1, no SRAM beat, resp_rdata=0.
  - BEAT1 is unreachable and may be removed.
  - Non-split misaligned accesses (e.g. LH at addr[1:0]=1) still succeed.

Test Plan:
- SW 0xDEADBEEF at 0x8000_0010, then LW 0x8000_0010 -> sram_be=4'b1111 on the write. Load returns resp_rdata=0xDEADBEEF with resp_valid at T+2.
- Word 0x8000_0020 holds 0x80FF_7F01 -> LB 0x8000_0023 returns 0xFFFF_FF80; LBU 0x8000_0023 returns 0x0000_0080; LH 0x8000_0021 returns 0xFFFF_FF7F... checked per-lane for all offsets.
- SH 0xA55A at 0x8000_0007 with the macro defined -> BEAT0 word 1 be=4'b1000 data[31:24]=0x5A; BEAT1 word 2 be=4'b0001 data[7:0]=0xA5. LHU of the same address returns 0x0000_A55A at T+3.
- Same SH with the macro undefined -> resp_err=1 at T+1, sram_ce never asserted.
- LW 0x7FFF_FFFC, LW at top word+1, rd_ctrl=6, and rd_ctrl=5 with wr_ctrl=3 -> each returns resp_err=1, resp_rdata=0, no SRAM access.
- Assert rst_n low during BEAT1 of a split store -> next cycle req_ready=1, resp_valid=0, sram_ce=0. The subsequent LW completes normally.

Source files
------------

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Memory-side responder for the core's data-SRAM port. Accepts
//               one load/store at a time, drives a single-port synchronous
//               word SRAM with byte enables, aligns and extends load data,
//               steers store bytes onto lanes and splits word-crossing
//               accesses into two beats.
//               Optional feature macro: DMEM_MISALIGN_SPLIT_EN (two-beat
//               split support; when undefined, split-class accesses error).
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder #(
  parameter int unsigned XLEN       = 32,
  parameter logic [31:0] ADDR_BASE  = 32'h8000_0000,
  parameter int unsigned DEPTH_LOG2 = 14
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [2:0]            req_rd_ctrl,
  input  logic [1:0]            req_wr_ctrl,
  input  logic [XLEN-1:0]       req_addr,
  input  logic [XLEN-1:0]       req_wdata,
  output logic                  resp_valid,
  output logic [XLEN-1:0]       resp_rdata,
  output logic                  resp_err,
  output logic                  sram_ce,
  output logic                  sram_we,
  output logic [3:0]            sram_be,
  output logic [DEPTH_LOG2-1:0] sram_addr,
  output logic [31:0]           sram_wdata,
  input  logic [31:0]           sram_rdata
);

  // Size of the SRAM window in bytes; one bit wider than an address so the
  // end-of-access comparison cannot wrap.
  localparam logic [32:0] MEM_BYTES = 33'd1 << (DEPTH_LOG2 + 2);

`ifdef DMEM_MISALIGN_SPLIT_EN
  localparam logic SPLIT_EN = 1'b1;
`else
  localparam logic SPLIT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BEAT0 = 2'd1,
    S_BEAT1 = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [2:0]            rd_q;
  logic [1:0]            wr_q;
  logic [1:0]            lane_q;
  logic [2:0]            size_q;
  logic [DEPTH_LOG2-1:0] widx_q;
  logic [31:0]           wdata_q;
  logic                  err_q;
  logic                  split_q;
  logic [31:0]           rdata0_q;

  // Request classification on the live request inputs.
  logic [31:0] off;
  logic [2:0]  size;
  logic [32:0] end_byte;
  logic        rd_illegal, both_ctrl, noop, out_of_range, split, req_err;

  // Decode access size, range and split class of the presented request.
  always_comb begin
    off = req_addr - ADDR_BASE;
    size = 3'd0;
    if (req_wr_ctrl != 2'd0) begin
      case (req_wr_ctrl)
        2'd1:    size = 3'd1;
        2'd2:    size = 3'd2;
        default: size = 3'd4;
      endcase
    end else begin
      case (req_rd_ctrl)
        3'd1, 3'd2: size = 3'd1;
        3'd3, 3'd4: size = 3'd2;
        3'd5:       size = 3'd4;
        default:    size = 3'd0;
      endcase
    end
    end_byte     = {1'b0, off} + {30'd0, size};
    rd_illegal   = (req_rd_ctrl > 3'd5);
    both_ctrl    = (req_rd_ctrl != 3'd0) && (req_wr_ctrl != 2'd0);
    noop         = (req_rd_ctrl == 3'd0) && (req_wr_ctrl == 2'd0);
    // Last accessed byte must lie inside the window; a start offset past the
    // top also trips this since size is at least one.
    out_of_range = (size != 3'd0) && (end_byte > MEM_BYTES);
    split        = (({1'b0, off[1:0]} + size) > 3'd4);
    req_err      = rd_illegal | both_ctrl | out_of_range | (split & ~SPLIT_EN);
  end

  // State register and request capture; reset abandons any transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      rd_q     <= 3'd0;
      wr_q     <= 2'd0;
      lane_q   <= 2'd0;
      size_q   <= 3'd0;
      widx_q   <= '0;
      wdata_q  <= 32'd0;
      err_q    <= 1'b0;
      split_q  <= 1'b0;
      rdata0_q <= 32'd0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && req_valid) begin
        rd_q    <= req_rd_ctrl;
        wr_q    <= req_wr_ctrl;
        lane_q  <= off[1:0];
        size_q  <= size;
        widx_q  <= off[DEPTH_LOG2+1:2];
        wdata_q <= req_wdata;
        err_q   <= req_err;
        split_q <= split;
      end
      // During BEAT1 the SRAM is presenting the first beat's word.
      if (state_q == S_BEAT1) begin
        rdata0_q <= sram_rdata;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          state_d = (req_err || noop) ? S_RESP : S_BEAT0;
        end
      end
      S_BEAT0: begin
`ifdef DMEM_MISALIGN_SPLIT_EN
        state_d = split_q ? S_BEAT1 : S_RESP;
`else
        state_d = S_RESP;
`endif
      end
      S_BEAT1: state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  logic [3:0]  size_mask;
  logic [7:0]  lane_mask;
  logic [4:0]  shamt;
  logic [31:0] wdata_rot;
  logic [63:0] rd_cat;
  logic [31:0] rd_raw;
  logic [31:0] rd_ext;
  logic        is_store;

  // SRAM drive, store lane steering, load assembly and response outputs.
  always_comb begin
    req_ready  = (state_q == S_IDLE);
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = '0;
    sram_ce    = 1'b0;
    sram_we    = 1'b0;
    sram_be    = 4'd0;
    sram_addr  = '0;
    sram_wdata = 32'd0;

    is_store = (wr_q != 2'd0);
    case (size_q)
      3'd1:    size_mask = 4'b0001;
      3'd2:    size_mask = 4'b0011;
      3'd4:    size_mask = 4'b1111;
      default: size_mask = 4'b0000;
    endcase
    // Low nibble: first-beat lanes; high nibble: bytes spilling into next word.
    lane_mask = {4'd0, size_mask} << lane_q;
    shamt     = {lane_q, 3'b000};
    wdata_rot = (wdata_q << shamt) | (wdata_q >> (6'd32 - {1'b0, shamt}));

    // Second word only matters for split loads, where it arrives live now.
    rd_cat = split_q ? {sram_rdata, rdata0_q} : {32'd0, sram_rdata};
    rd_raw = 32'(rd_cat >> shamt);
    case (rd_q)
      3'd1:    rd_ext = {{24{rd_raw[7]}}, rd_raw[7:0]};
      3'd2:    rd_ext = {24'd0, rd_raw[7:0]};
      3'd3:    rd_ext = {{16{rd_raw[15]}}, rd_raw[15:0]};
      3'd4:    rd_ext = {16'd0, rd_raw[15:0]};
      default: rd_ext = rd_raw;
    endcase

    case (state_q)
      S_BEAT0: begin
        sram_ce   = 1'b1;
        sram_we   = is_store;
        sram_addr = widx_q;
        if (is_store) begin
          sram_be    = lane_mask[3:0];
          sram_wdata = wdata_rot;
        end
      end
      S_BEAT1: begin
        sram_ce   = 1'b1;
        sram_we   = is_store;
        sram_addr = widx_q + 1'b1;
        if (is_store) begin
          sram_be    = lane_mask[7:4];
          sram_wdata = wdata_rot;
        end
      end
      S_RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        if (!err_q && rd_q != 3'd0) begin
          resp_rdata = rd_ext;
        end
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_responder
// Description : Self-checking bench for dmem_responder. Table of directed
//               vectors, hand sequences for split/reset corners, and random
//               traffic checked against a byte-array reference memory.
//               Honours DMEM_MISALIGN_SPLIT_EN like the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

  localparam logic [31:0] BASE   = 32'h8000_0000;
  localparam int          DLOG2  = 14;
  localparam int          WORDS  = 1 << DLOG2;
  localparam int          NBYTES = WORDS * 4;
`ifdef DMEM_MISALIGN_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  logic             clk, rst_n;
  logic             req_valid, req_ready;
  logic [2:0]       req_rd_ctrl;
  logic [1:0]       req_wr_ctrl;
  logic [31:0]      req_addr, req_wdata;
  logic             resp_valid, resp_err;
  logic [31:0]      resp_rdata;
  logic             sram_ce, sram_we;
  logic [3:0]       sram_be;
  logic [DLOG2-1:0] sram_addr;
  logic [31:0]      sram_wdata, sram_rdata;

  dmem_responder #(.XLEN(32), .ADDR_BASE(BASE), .DEPTH_LOG2(DLOG2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rd_ctrl(req_rd_ctrl), .req_wr_ctrl(req_wr_ctrl),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .sram_ce(sram_ce), .sram_we(sram_we), .sram_be(sram_be),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural synchronous-read SRAM with byte enables.
  logic [31:0] mem [WORDS];
  logic        mem_clear;
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < WORDS; i++) mem[i] <= 32'd0;
    end else if (sram_ce) begin
      if (sram_we) begin
        for (int l = 0; l < 4; l++)
          if (sram_be[l]) mem[sram_addr][l*8 +: 8] <= sram_wdata[l*8 +: 8];
      end else begin
        sram_rdata <= mem[sram_addr];
      end
    end
  end

  // Reference model state: flat byte memory of the window.
  logic [7:0] ref_mem [NBYTES];

  int n_tests = 0;
  int n_fail  = 0;

  // Beats seen during the last transaction.
  int               b_n;
  logic [DLOG2-1:0] b_addr [2];
  logic [3:0]       b_be   [2];
  logic [31:0]      b_wd   [2];
  logic             b_we   [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one request from an IDLE cycle and observe it to completion.
  task automatic run(input logic [2:0] rd, input logic [1:0] wr, input logic [31:0] addr,
                     input logic [31:0] wdata, output logic [31:0] rdata,
                     output logic err, output int lat);
    bit done;
    check("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_rd_ctrl = rd; req_wr_ctrl = wr; req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0; req_rd_ctrl = 3'd0; req_wr_ctrl = 2'd0;
    b_n = 0; lat = 0; rdata = 32'd0; err = 1'b0; done = 1'b0;
    for (int k = 1; k <= 8 && !done; k++) begin
      if (sram_ce) begin
        if (b_n < 2) begin
          b_addr[b_n] = sram_addr; b_be[b_n] = sram_be;
          b_wd[b_n] = sram_wdata; b_we[b_n] = sram_we;
        end
        b_n++;
      end
      if (resp_valid) begin
        done = 1'b1; lat = k; rdata = resp_rdata; err = resp_err;
        check("req_ready_resp", 32'(req_ready), 32'd0);
      end else begin
        @(posedge clk); #1;
      end
    end
    if (!done) begin
      n_tests++; n_fail++;
      $display("FAIL timeout: no resp_valid within 8 cycles of accept");
    end
    @(posedge clk); #1;
    check("resp_pulse", 32'(resp_valid), 32'd0);
  endtask

  // Run one request and check it against the byte-level reference model.
  task automatic xact(input logic [2:0] rd, input logic [1:0] wr, input logic [31:0] addr,
                      input logic [31:0] wdata, output logic [31:0] got,
                      output logic got_err, output int got_lat);
    int          sz, exp_lat, exp_beats;
    logic [31:0] off, exp_rd, v;
    logic [3:0]  ebe;
    bit          noop, split, err;
    if (wr == 2'd1 || rd == 3'd1 || rd == 3'd2) sz = 1;
    else if (wr == 2'd2 || rd == 3'd3 || rd == 3'd4) sz = 2;
    else if (wr == 2'd3 || rd == 3'd5) sz = 4;
    else sz = 0;
    if (wr != 2'd0 && wr == 2'd1) sz = 1;
    off   = addr - BASE;
    noop  = (rd == 3'd0) && (wr == 2'd0);
    split = (sz > 0) && (int'(off[1:0]) + sz > 4);
    err   = (rd > 3'd5) || (rd != 3'd0 && wr != 2'd0) ||
            ((sz > 0) && (({32'd0, off} + 64'(sz)) > 64'(NBYTES))) || (split && !SPLIT_EN);
    exp_lat   = (err || noop) ? 1 : (split ? 3 : 2);
    exp_beats = (err || noop) ? 0 : (split ? 2 : 1);
    exp_rd    = 32'd0;
    if (!err && rd != 3'd0) begin
      v = 32'd0;
      for (int i = 0; i < sz; i++) v[i*8 +: 8] = ref_mem[int'(off) + i];
      if (rd == 3'd1 && v[7])  v = v | 32'hFFFF_FF00;
      if (rd == 3'd3 && v[15]) v = v | 32'hFFFF_0000;
      exp_rd = v;
    end

    run(rd, wr, addr, wdata, got, got_err, got_lat);

    check("err", 32'(got_err), 32'(err));
    check("rdata", got, exp_rd);
    check("latency", 32'(got_lat), 32'(exp_lat));
    check("beats", 32'(b_n), 32'(exp_beats));
    for (int j = 0; j < b_n && j < 2; j++) begin
      check("beat_we", 32'(b_we[j]), 32'(wr != 2'd0));
      check("beat_addr", 32'(b_addr[j]), ((off >> 2) + 32'(j)) & 32'(WORDS - 1));
      if (wr != 2'd0) begin
        ebe = 4'd0;
        for (int i = 0; i < sz; i++) begin
          if (((off + 32'(i)) >> 2) == ((off >> 2) + 32'(j))) begin
            ebe[(int'(off) + i) % 4] = 1'b1;
            check("beat_lane_data", 32'(b_wd[j][((int'(off) + i) % 4)*8 +: 8]), 32'(wdata[i*8 +: 8]));
          end
        end
        check("beat_be", 32'(b_be[j]), 32'(ebe));
      end
    end
    if (!err && wr != 2'd0)
      for (int i = 0; i < sz; i++) ref_mem[int'(off) + i] = wdata[i*8 +: 8];
  endtask

  typedef struct {
    logic [2:0]  rd;
    logic [1:0]  wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  localparam int NV = 23;
  vec_t tbl [NV];

  initial begin
    logic [31:0] r;
    logic        e;
    int          l, kind, reg_sel;
    logic [2:0]  rd;
    logic [1:0]  wr;
    logic [31:0] off;

    tbl[0]  = '{3'd0, 2'd3, 32'h8000_0020, 32'h80FF_7F01, 32'h0000_0000, 1'b0, 2};
    tbl[1]  = '{3'd1, 2'd0, 32'h8000_0023, 32'h0,         32'hFFFF_FF80, 1'b0, 2};
    tbl[2]  = '{3'd2, 2'd0, 32'h8000_0023, 32'h0,         32'h0000_0080, 1'b0, 2};
    tbl[3]  = '{3'd3, 2'd0, 32'h8000_0021, 32'h0,         32'hFFFF_FF7F, 1'b0, 2};
    tbl[4]  = '{3'd4, 2'd0, 32'h8000_0022, 32'h0,         32'h0000_80FF, 1'b0, 2};
    tbl[5]  = '{3'd1, 2'd0, 32'h8000_0020, 32'h0,         32'h0000_0001, 1'b0, 2};
    tbl[6]  = '{3'd1, 2'd0, 32'h8000_0021, 32'h0,         32'h0000_007F, 1'b0, 2};
    tbl[7]  = '{3'd1, 2'd0, 32'h8000_0022, 32'h0,         32'hFFFF_FFFF, 1'b0, 2};
    tbl[8]  = '{3'd2, 2'd0, 32'h8000_0022, 32'h0,         32'h0000_00FF, 1'b0, 2};
    tbl[9]  = '{3'd3, 2'd0, 32'h8000_0020, 32'h0,         32'h0000_7F01, 1'b0, 2};
    tbl[10] = '{3'd4, 2'd0, 32'h8000_0021, 32'h0,         32'h0000_FF7F, 1'b0, 2};
    tbl[11] = '{3'd5, 2'd0, 32'h8000_0020, 32'h0,         32'h80FF_7F01, 1'b0, 2};
    tbl[12] = '{3'd5, 2'd0, 32'h7FFF_FFFC, 32'h0,         32'h0000_0000, 1'b1, 1};
    tbl[13] = '{3'd5, 2'd0, 32'h8001_0000, 32'h0,         32'h0000_0000, 1'b1, 1};
    tbl[14] = '{3'd6, 2'd0, 32'h8000_0020, 32'h0,         32'h0000_0000, 1'b1, 1};
    tbl[15] = '{3'd5, 2'd3, 32'h8000_0020, 32'h1234_5678, 32'h0000_0000, 1'b1, 1};
    tbl[16] = '{3'd7, 2'd0, 32'h8000_0020, 32'h0,         32'h0000_0000, 1'b1, 1};
    tbl[17] = '{3'd0, 2'd0, 32'h8000_0020, 32'h0,         32'h0000_0000, 1'b0, 1};
    tbl[18] = '{3'd0, 2'd1, 32'h8000_FFFF, 32'h0000_00AB, 32'h0000_0000, 1'b0, 2};
    tbl[19] = '{3'd2, 2'd0, 32'h8000_FFFF, 32'h0,         32'h0000_00AB, 1'b0, 2};
    tbl[20] = '{3'd3, 2'd0, 32'h8000_FFFF, 32'h0,         32'h0000_0000, 1'b1, 1};
    tbl[21] = '{3'd0, 2'd1, 32'h8000_0021, 32'h0000_0055, 32'h0000_0000, 1'b0, 2};
    tbl[22] = '{3'd5, 2'd0, 32'h8000_0020, 32'h0,         32'h80FF_5501, 1'b0, 2};

    for (int i = 0; i < NBYTES; i++) ref_mem[i] = 8'd0;
    rst_n = 1'b0; mem_clear = 1'b1;
    req_valid = 1'b0; req_rd_ctrl = 3'd0; req_wr_ctrl = 2'd0;
    req_addr = 32'd0; req_wdata = 32'd0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready",  32'(req_ready),  32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_err",   32'(resp_err),   32'd0);
    check("rst_resp_rdata", resp_rdata,      32'd0);
    check("rst_sram_ce",    32'(sram_ce),    32'd0);
    check("rst_sram_we",    32'(sram_we),    32'd0);
    check("rst_sram_be",    32'(sram_be),    32'd0);
    mem_clear = 1'b0; rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors.
    for (int i = 0; i < NV; i++) begin
      xact(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata, r, e, l);
      check("tbl_rdata", r, tbl[i].exp_rdata);
      check("tbl_err", 32'(e), 32'(tbl[i].exp_err));
      check("tbl_latency", 32'(l), 32'(tbl[i].exp_lat));
    end

    // Aligned word store then load.
    xact(3'd0, 2'd3, 32'h8000_0010, 32'hDEAD_BEEF, r, e, l);
    check("sw_be", 32'(b_be[0]), 32'h0000_000F);
    check("sw_word", 32'(b_addr[0]), 32'd4);
    xact(3'd5, 2'd0, 32'h8000_0010, 32'h0, r, e, l);
    check("lw_rdata", r, 32'hDEAD_BEEF);
    check("lw_latency", 32'(l), 32'd2);

    // Word-crossing halfword store.
    xact(3'd0, 2'd2, 32'h8000_0007, 32'h0000_A55A, r, e, l);
`ifdef DMEM_MISALIGN_SPLIT_EN
    check("sh_split_latency", 32'(l), 32'd3);
    check("sh_b0_word", 32'(b_addr[0]), 32'd1);
    check("sh_b0_be",   32'(b_be[0]), 32'h8);
    check("sh_b0_data", 32'(b_wd[0][31:24]), 32'h5A);
    check("sh_b1_word", 32'(b_addr[1]), 32'd2);
    check("sh_b1_be",   32'(b_be[1]), 32'h1);
    check("sh_b1_data", 32'(b_wd[1][7:0]), 32'hA5);
    xact(3'd4, 2'd0, 32'h8000_0007, 32'h0, r, e, l);
    check("lhu_split_rdata", r, 32'h0000_A55A);
    check("lhu_split_latency", 32'(l), 32'd3);
`else
    check("sh_split_err", 32'(e), 32'd1);
    check("sh_split_latency", 32'(l), 32'd1);
    check("sh_split_no_ce", 32'(b_n), 32'd0);
`endif

    // Reset asserted during the final beat of a store.
    req_valid = 1'b1; req_wr_ctrl = 2'd3; req_rd_ctrl = 3'd0;
    req_addr = SPLIT_EN ? 32'h8000_1001 : 32'h8000_1000; req_wdata = 32'h1357_9BDF;
    @(posedge clk); #1;
    req_valid = 1'b0; req_wr_ctrl = 2'd0;
    check("abort_beat0_ce", 32'(sram_ce), 32'd1);
`ifdef DMEM_MISALIGN_SPLIT_EN
    @(posedge clk); #1;
    check("abort_beat1_ce", 32'(sram_ce), 32'd1);
    check("abort_beat1_be", 32'(sram_be), 32'h1);
`endif
    rst_n = 1'b0;
    #1;
    check("abort_req_ready",  32'(req_ready),  32'd1);
    check("abort_resp_valid", 32'(resp_valid), 32'd0);
    check("abort_sram_ce",    32'(sram_ce),    32'd0);
    @(posedge clk); #1;
    check("abort_next_resp_valid", 32'(resp_valid), 32'd0);
    check("abort_next_sram_ce",    32'(sram_ce),    32'd0);
    check("abort_next_req_ready",  32'(req_ready),  32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;
    xact(3'd5, 2'd0, 32'h8000_0010, 32'h0, r, e, l);
    check("post_abort_lw", r, 32'hDEAD_BEEF);

    // Random traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      kind    = int'($urandom_range(0, 19));
      reg_sel = int'($urandom_range(0, 9));
      if (reg_sel < 7)      off = 32'h100 + $urandom_range(0, 63);
      else if (reg_sel < 9) off = 32'hFFF0 + $urandom_range(0, 15);
      else if ($urandom_range(0, 1) == 0) off = 32'h1_0000 + $urandom_range(0, 7);
      else                  off = 32'hFFFF_FFF0 + $urandom_range(0, 15);
      rd = 3'd0; wr = 2'd0;
      if (kind < 9)       rd = 3'($urandom_range(1, 5));
      else if (kind < 18) wr = 2'($urandom_range(1, 3));
      else if (kind == 18) begin
        if ($urandom_range(0, 1) == 0) rd = 3'($urandom_range(6, 7));
        else begin rd = 3'($urandom_range(1, 5)); wr = 2'($urandom_range(1, 3)); end
      end
      xact(rd, wr, BASE + off, $urandom, r, e, l);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
